uart_tx_fifo: RTL and testbench

//  Byte FIFO and transmit sequencer placed directly upstream of the UART core.

---
 rtl/uart_tx_fifo.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus transmit sequencer sitting in front of a UART core.
// Bytes are handed to the UART over the tx_start/tx_data/tx_busy handshake. The
// head byte stays in the FIFO until the UART acknowledges it by raising tx_busy.
// If the UART ignores a request, the same byte is offered again after a timeout.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2  = 4,
  parameter int ACK_TIMEOUT = 4,
  parameter int GAP_CYCLES  = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          wr_data,
  input  logic                wr_en,
  input  logic                flush,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] level,
  output logic                overflow,
  output logic [7:0]          tx_data,
  output logic                tx_start,
  input  logic                tx_busy,
  input  logic                rx_busy
);

  localparam int DEPTH   = 2 ** DEPTH_LOG2;
  localparam int LVL_W   = DEPTH_LOG2 + 1;
  localparam int CNT_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [LVL_W-1:0]      LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0]      LVL_FULL = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]      ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]      GAP_LAST = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_GAP
  } state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [7:0]            tx_data_q;
  logic                  tx_start_q;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  overflow_q, overflow_d;
  logic                  pop;
  logic                  wr_ok;

  // Next-state of the FIFO bookkeeping: pointers, level counter and flags.
  // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
  always_comb begin
    // The head leaves the FIFO only when the UART acknowledges; an ACK that
    // arrives after a flush finds the FIFO empty and pops nothing.
    pop        = (state_q == S_WAIT_ACK) && tx_busy && !empty_q;
    wr_ok      = wr_en && !flush && (!full_q || pop);
    overflow_d = wr_en && !flush && full_q && !pop;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (wr_ok && !pop)      level_d = level_q + LVL_ONE;
      else if (pop && !wr_ok) level_d = level_q - LVL_ONE;
    end
    full_d  = (level_d == LVL_FULL);
    empty_d = (level_d == '0);
  end

  // FIFO state registers; flags are registered from the next level.
  // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Byte storage.
  // NOTE: the array has no reset; contents are only read behind a valid level, so it maps to plain RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_data;
  end

  // Transmit sequencer: issue, wait for acknowledge or time out, wait for frame end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (!empty_q && !rx_busy && !tx_busy) state_q <= S_START;
        end
        S_START: begin
          // Re-check the launch conditions so a flush or a late busy cannot
          // produce a request with stale data or on top of a busy UART.
          if (empty_q || rx_busy || tx_busy) begin
            state_q <= S_IDLE;
          end else begin
            tx_data_q  <= mem[rd_ptr_q];
            tx_start_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (tx_busy) begin
            state_q <= S_WAIT_DONE;
          end else if (cnt_q == ACK_LAST) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            if (GAP_CYCLES > 0) begin
              cnt_q   <= '0;
              state_q <= S_GAP;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) state_q <= S_IDLE;
          else                   cnt_q   <= cnt_q + CNT_ONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;
  assign overflow = overflow_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: a UART model acknowledges requests (optionally
// ignoring some), and a scoreboard queue holds the bytes expected on tx_data.
module tb_uart_tx_fifo;

  localparam int DEPTH_LOG2  = 4;
  localparam int ACK_TIMEOUT = 4;
  localparam int GAP_CYCLES  = 0;
  localparam int FRAME       = 10;

  logic                clk = 1'b0;
  logic                reset;
  logic [7:0]          wr_data;
  logic                wr_en;
  logic                flush;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] level;
  logic                overflow;
  logic [7:0]          tx_data;
  logic                tx_start;
  logic                tx_busy;
  logic                rx_busy;

  int          n_checks;
  int          n_pass;
  logic [7:0]  exp_q[$];
  int          start_cnt;
  int          ovf_cnt;
  int          ignore_n;
  int          busy_left;
  bit          pend;
  bit          prev_start;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .flush   (flush),
    .full    (full),
    .empty   (empty),
    .level   (level),
    .overflow(overflow),
    .tx_data (tx_data),
    .tx_start(tx_start),
    .tx_busy (tx_busy),
    .rx_busy (rx_busy)
  );

  // UART model and start monitor, evaluated on every falling edge.
  task automatic model_loop();
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        start_cnt++;
        n_checks++;
        if (tx_busy !== 1'b0) $display("FAIL start_while_busy: tx_busy=%b required 0", tx_busy);
        else n_pass++;
        n_checks++;
        if (prev_start !== 1'b0) $display("FAIL start_consecutive: tx_start high two cycles, required single pulse");
        else n_pass++;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL sb_data: tx_data=%h issued, required no start", tx_data);
        else if (tx_data !== exp_q[0]) $display("FAIL sb_data: tx_data=%h required %h", tx_data, exp_q[0]);
        else n_pass++;
      end
      prev_start = tx_start;
      if (overflow === 1'b1) ovf_cnt++;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_busy = 1'b0;
      end else if (pend) begin
        pend      = 1'b0;
        tx_busy   = 1'b1;
        busy_left = FRAME;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (tx_start === 1'b1) begin
        if (ignore_n > 0) ignore_n--;
        else pend = 1'b1;
      end
    end
  endtask

  task automatic wait_quiet(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (empty && !tx_busy && !pend && busy_left == 0 && !tx_start) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (empty !== 1'b1) $display("FAIL rst_empty: got %b required 1", empty); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL rst_full: got %b required 0", full); else n_pass++;
    n_checks++; if (level !== 5'd0) $display("FAIL rst_level: got %0d required 0", level); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL rst_overflow: got %b required 0", overflow); else n_pass++;
    n_checks++; if (tx_start !== 1'b0) $display("FAIL rst_tx_start: got %b required 0", tx_start); else n_pass++;
    n_checks++; if (tx_data !== 8'h00) $display("FAIL rst_tx_data: got %h required 00", tx_data); else n_pass++;
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int s0;
    bit ok;
    s0 = start_cnt;
    @(negedge clk); wr_en = 1'b1; wr_data = 8'h55; exp_q.push_back(8'h55);
    @(negedge clk); wr_data = 8'hA3; exp_q.push_back(8'hA3);
    @(negedge clk); wr_en = 1'b0;
    n_checks++; if (level !== 5'd2) $display("FAIL basic_level_2: got %0d required 2", level); else n_pass++;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (level == 5'd1) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) $display("FAIL basic_level_1: got %0d required 1 within 40 cycles", level); else n_pass++;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (level == 5'd0) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) $display("FAIL basic_level_0: got %0d required 0 within 40 cycles", level); else n_pass++;
    wait_quiet(60, ok);
    n_checks++; if (empty !== 1'b1) $display("FAIL basic_empty: got %b required 1", empty); else n_pass++;
    n_checks++; if (start_cnt - s0 != 2) $display("FAIL basic_starts: got %0d required 2", start_cnt - s0); else n_pass++;
  endtask

  task automatic test_fill_overflow();
    int o0;
    o0 = ovf_cnt;
    @(negedge clk); rx_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 15) begin
        n_checks++; if (full !== 1'b0) $display("FAIL fill_full_at_15: got %b required 0", full); else n_pass++;
      end
      if (i == 16) begin
        n_checks++; if (full !== 1'b1) $display("FAIL fill_full_at_16: got %b required 1", full); else n_pass++;
        n_checks++; if (level !== 5'd16) $display("FAIL fill_level_16: got %0d required 16", level); else n_pass++;
      end
      wr_en   = 1'b1;
      wr_data = 8'(16 + i);
      if (i < 16) exp_q.push_back(8'(16 + i));
    end
    @(negedge clk); wr_en = 1'b0;
    n_checks++; if (overflow !== 1'b1) $display("FAIL fill_overflow_pulse: got %b required 1", overflow); else n_pass++;
    n_checks++; if (level !== 5'd16) $display("FAIL fill_level_after_drop: got %0d required 16", level); else n_pass++;
    @(negedge clk);
    n_checks++; if (overflow !== 1'b0) $display("FAIL fill_overflow_clear: got %b required 0", overflow); else n_pass++;
    n_checks++; if (ovf_cnt - o0 != 1) $display("FAIL fill_overflow_count: got %0d required 1", ovf_cnt - o0); else n_pass++;
  endtask

  task automatic test_rx_busy_hold();
    int s0;
    int found;
    s0 = start_cnt;
    repeat (20) @(negedge clk);
    n_checks++; if (start_cnt != s0) $display("FAIL rxb_no_start: got %0d starts required 0", start_cnt - s0); else n_pass++;
    n_checks++; if (level !== 5'd16) $display("FAIL rxb_level: got %0d required 16", level); else n_pass++;
    rx_busy = 1'b0;
    found = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (tx_start) begin found = k; break; end
    end
    n_checks++;
    if (found < 1 || found > 2) $display("FAIL rxb_release_start: got start after %0d cycles required 1..2", found);
    else n_pass++;
  endtask

  // Entered on the cycle the first request after rx_busy release is visible.
  task automatic test_write_on_ack();
    int o0;
    bit ok;
    o0 = ovf_cnt;
    @(negedge clk); wr_en = 1'b1; wr_data = 8'hEE; exp_q.push_back(8'hEE);
    @(negedge clk); wr_en = 1'b0;
    n_checks++; if (level !== 5'd16) $display("FAIL ackwr_level: got %0d required 16", level); else n_pass++;
    n_checks++; if (full !== 1'b1) $display("FAIL ackwr_full: got %b required 1", full); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL ackwr_overflow: got %b required 0", overflow); else n_pass++;
    @(negedge clk);
    n_checks++; if (ovf_cnt != o0) $display("FAIL ackwr_overflow_count: got %0d required 0", ovf_cnt - o0); else n_pass++;
    wait_quiet(17 * (FRAME + 8) + 50, ok);
    n_checks++; if (!ok) $display("FAIL ackwr_drain: FIFO not drained, level=%0d required 0", level); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL ackwr_sb_left: got %0d bytes required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_timeout_reissue();
    int s0;
    int t1;
    int t2;
    logic [DEPTH_LOG2:0] lvl2;
    bit ok;
    s0 = start_cnt;
    ignore_n = 1;
    t1 = -1;
    t2 = -1;
    lvl2 = '0;
    @(negedge clk); wr_en = 1'b1; wr_data = 8'h3C; exp_q.push_back(8'h3C);
    @(negedge clk); wr_en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_start) begin
        if (t1 < 0) t1 = i;
        else begin t2 = i; lvl2 = level; break; end
      end
    end
    n_checks++; if (t2 < 0) $display("FAIL to_reissue_seen: got t1=%0d t2=%0d required two starts", t1, t2); else n_pass++;
    n_checks++;
    if (t2 - t1 < ACK_TIMEOUT || t2 - t1 > ACK_TIMEOUT + 3)
      $display("FAIL to_reissue_delay: got %0d cycles required %0d..%0d", t2 - t1, ACK_TIMEOUT, ACK_TIMEOUT + 3);
    else n_pass++;
    n_checks++; if (lvl2 !== 5'd1) $display("FAIL to_level_held: got %0d required 1", lvl2); else n_pass++;
    wait_quiet(60, ok);
    n_checks++; if (level !== 5'd0) $display("FAIL to_level_after_ack: got %0d required 0", level); else n_pass++;
    n_checks++; if (start_cnt - s0 != 2) $display("FAIL to_starts: got %0d required 2", start_cnt - s0); else n_pass++;
  endtask

  task automatic test_flush();
    int s0;
    int o0;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = 8'(8'hA0 + i);
      exp_q.push_back(8'(8'hA0 + i));
    end
    @(negedge clk); wr_en = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tx_busy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++; if (!ok) $display("FAIL flush_frame_started: tx_busy=%b required 1", tx_busy); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if (level !== 5'd5) $display("FAIL flush_level_before: got %0d required 5", level); else n_pass++;
    o0 = ovf_cnt;
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
    exp_q.delete();
    @(negedge clk); flush = 1'b0; wr_en = 1'b0;
    n_checks++; if (level !== 5'd0) $display("FAIL flush_level_after: got %0d required 0", level); else n_pass++;
    n_checks++; if (empty !== 1'b1) $display("FAIL flush_empty: got %b required 1", empty); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL flush_overflow: got %b required 0", overflow); else n_pass++;
    s0 = start_cnt;
    repeat (FRAME + 10) @(negedge clk);
    n_checks++; if (start_cnt != s0) $display("FAIL flush_no_start: got %0d starts required 0", start_cnt - s0); else n_pass++;
    n_checks++; if (level !== 5'd0) $display("FAIL flush_level_settled: got %0d required 0", level); else n_pass++;
    n_checks++; if (ovf_cnt != o0) $display("FAIL flush_overflow_count: got %0d required 0", ovf_cnt - o0); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    bit found;
    ignore_n = 1;
    @(negedge clk); wr_en = 1'b1; wr_data = 8'h99; exp_q.push_back(8'h99);
    @(negedge clk); wr_en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_start) begin found = 1'b1; break; end
    end
    n_checks++; if (!found) $display("FAIL rstmid_start_seen: tx_start=%b required 1 within 10 cycles", tx_start); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++; if (tx_data !== 8'h00) $display("FAIL rstmid_tx_data: got %h required 00", tx_data); else n_pass++;
    n_checks++; if (tx_start !== 1'b0) $display("FAIL rstmid_tx_start: got %b required 0", tx_start); else n_pass++;
    n_checks++; if (level !== 5'd0) $display("FAIL rstmid_level: got %0d required 0", level); else n_pass++;
    n_checks++; if (empty !== 1'b1) $display("FAIL rstmid_empty: got %b required 1", empty); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL rstmid_full: got %b required 0", full); else n_pass++;
    exp_q.delete();
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    wr_en      = 1'b0;
    wr_data    = 8'h00;
    flush      = 1'b0;
    rx_busy    = 1'b0;
    tx_busy    = 1'b0;
    n_checks   = 0;
    n_pass     = 0;
    start_cnt  = 0;
    ovf_cnt    = 0;
    ignore_n   = 0;
    busy_left  = 0;
    pend       = 1'b0;
    prev_start = 1'b0;
    fork
      model_loop();
    join_none
    test_reset();
    test_basic();
    test_fill_overflow();
    test_rx_busy_hold();
    test_write_on_ack();
    test_timeout_reissue();
    test_flush();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
